// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin share of one ALU between two ports, single registered response slot; ALU_ARB_LOCK_EN adds port locking
module alu_share_arbiter #(
  parameter bit PRIO_INIT = 1'b0,
  parameter int LOCK_MAX  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [3:0]  req0_cntrl,
  input  logic [31:0] req0_in1,
  input  logic [31:0] req0_in2,
  input  logic        req0_lock,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [3:0]  req1_cntrl,
  input  logic [31:0] req1_in1,
  input  logic [31:0] req1_in2,
  input  logic        req1_lock,
  input  logic        rsp0_ready,
  input  logic        rsp1_ready,
  output logic        rsp0_valid,
  output logic        rsp1_valid,
  output logic [31:0] rsp_result,
  output logic        rsp_zero,
  output logic        rsp_err
);
  logic        slot_valid_q, slot_owner_q, prio_q, zero_q, err_q;
  logic [31:0] result_q;
  logic        drain, can_issue, any_v, gnt, accept, alu_err;
  logic [3:0]  op;
  logic [31:0] a, b, alu_res;
  assign drain     = slot_valid_q && (slot_owner_q ? rsp1_ready : rsp0_ready);
  assign can_issue = !slot_valid_q || drain;
`ifdef ALU_ARB_LOCK_EN
  localparam int CW = $clog2(LOCK_MAX + 1);
  logic          lock_q, lock_owner_q, lock_d;
  logic [CW-1:0] lock_cnt_q, lock_cnt_d;
  assign any_v      = lock_q ? (lock_owner_q ? req1_valid : req0_valid) : (req0_valid || req1_valid);
  assign gnt        = lock_q ? lock_owner_q : req1_valid && (!req0_valid || prio_q);
  assign lock_cnt_d = lock_q ? lock_cnt_q + CW'(1) : CW'(1);
  assign lock_d     = (gnt ? req1_lock : req0_lock) && lock_cnt_d < CW'(LOCK_MAX);
  always_ff @(posedge clk) begin
    if (reset || (accept && !lock_d)) begin
      lock_q       <= 1'b0;
      lock_owner_q <= 1'b0;
      lock_cnt_q   <= '0;
    end else if (accept) begin
      lock_q       <= 1'b1;
      lock_owner_q <= gnt;
      lock_cnt_q   <= lock_cnt_d;
    end
  end
`else
  logic unused_lock;
  assign unused_lock = ^{req0_lock, req1_lock, LOCK_MAX[0]};
  assign any_v       = req0_valid || req1_valid;
  assign gnt         = req1_valid && (!req0_valid || prio_q);
`endif
  assign accept     = can_issue && any_v && !reset;
  assign req0_ready = accept && !gnt;
  assign req1_ready = accept && gnt;
  assign op  = gnt ? req1_cntrl : req0_cntrl;
  assign a   = gnt ? req1_in1 : req0_in1;
  assign b   = gnt ? req1_in2 : req0_in2;
  assign alu_err = !(op inside {4'b0000, 4'b0001, 4'b0010, 4'b0110});
  assign alu_res = op == 4'b0000 ? a & b :
                   op == 4'b0001 ? a | b :
                   op == 4'b0010 ? a + b :
                   op == 4'b0110 ? a - b : '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_valid_q <= 1'b0;
      slot_owner_q <= 1'b0;
      result_q     <= '0;
      zero_q       <= 1'b0;
      err_q        <= 1'b0;
      prio_q       <= PRIO_INIT;
    end else if (accept) begin
      slot_valid_q <= 1'b1;
      slot_owner_q <= gnt;
      result_q     <= alu_res;
      zero_q       <= !alu_err && alu_res == '0;
      err_q        <= alu_err;
      prio_q       <= !gnt;
    end else if (drain) begin
      slot_valid_q <= 1'b0;
    end
  end
  assign rsp0_valid = slot_valid_q && !slot_owner_q;
  assign rsp1_valid = slot_valid_q && slot_owner_q;
  assign rsp_result = result_q;
  assign rsp_zero   = zero_q;
  assign rsp_err    = err_q;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed stimulus with a per-cycle reference model of the shared-ALU arbiter
module tb_alu_share_arbiter;
  localparam bit PRIO_INIT = 1'b0;
  localparam int LOCK_MAX  = 8;
  logic        clk = 1'b0, reset;
  logic        req0_valid, req0_ready, req0_lock, req1_valid, req1_ready, req1_lock;
  logic [3:0]  req0_cntrl, req1_cntrl;
  logic [31:0] req0_in1, req0_in2, req1_in1, req1_in2, rsp_result;
  logic        rsp0_ready, rsp1_ready, rsp0_valid, rsp1_valid, rsp_zero, rsp_err;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  alu_share_arbiter #(.PRIO_INIT(PRIO_INIT), .LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_cntrl(req0_cntrl),
    .req0_in1(req0_in1), .req0_in2(req0_in2), .req0_lock(req0_lock),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_cntrl(req1_cntrl),
    .req1_in1(req1_in1), .req1_in2(req1_in2), .req1_lock(req1_lock),
    .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err)
  );
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask
  function automatic logic [33:0] alu_ref(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] r;
    logic e;
    case (c)
      4'b0000: r = x & y;
      4'b0001: r = x | y;
      4'b0010: r = x + y;
      4'b0110: r = x - y;
      default: r = 32'd0;
    endcase
    e = !(c inside {4'b0000, 4'b0001, 4'b0010, 4'b0110});
    return {e, !e && r == 32'd0, r};
  endfunction
  bit          m_valid = 0, m_owner = 0, m_prio = PRIO_INIT, m_zero = 0, m_err = 0;
  logic [31:0] m_res = 0;
`ifdef ALU_ARB_LOCK_EN
  bit m_lk = 0, m_lown = 0;
  int m_lcnt = 0;
`endif
  always @(negedge clk) begin
    bit v[2];
    bit g, any, acc, drn;
    logic [33:0] r;
    v[0] = req0_valid;
    v[1] = req1_valid;
    drn = m_valid && (m_owner ? rsp1_ready : rsp0_ready);
    any = v[0] || v[1];
    g   = (v[0] && v[1]) ? m_prio : v[1];
`ifdef ALU_ARB_LOCK_EN
    if (m_lk) begin
      g   = m_lown;
      any = v[m_lown];
    end
`endif
    acc = !reset && any && (!m_valid || drn);
    chk("req0_ready", req0_ready, acc && !g);
    chk("req1_ready", req1_ready, acc && g);
    chk("rsp0_valid", rsp0_valid, m_valid && !m_owner);
    chk("rsp1_valid", rsp1_valid, m_valid && m_owner);
    chk("rsp_result", rsp_result, m_res);
    chk("rsp_zero", rsp_zero, m_zero);
    chk("rsp_err", rsp_err, m_err);
    if (reset) begin
      m_valid = 0; m_owner = 0; m_res = 0; m_zero = 0; m_err = 0; m_prio = PRIO_INIT;
`ifdef ALU_ARB_LOCK_EN
      m_lk = 0; m_lown = 0; m_lcnt = 0;
`endif
    end else if (acc) begin
      r = g ? alu_ref(req1_cntrl, req1_in1, req1_in2) : alu_ref(req0_cntrl, req0_in1, req0_in2);
      {m_err, m_zero, m_res} = r;
      m_valid = 1;
      m_owner = g;
      m_prio  = !g;
`ifdef ALU_ARB_LOCK_EN
      m_lcnt = m_lk ? m_lcnt + 1 : 1;
      m_lown = g;
      m_lk   = (g ? req1_lock : req0_lock) && m_lcnt < LOCK_MAX;
      if (!m_lk) m_lcnt = 0;
`endif
    end else if (drn) begin
      m_valid = 0;
    end
  end
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input bit p, input logic [3:0] c, input logic [31:0] x, input logic [31:0] y, input bit lk);
    if (p) begin
      req1_valid = 1; req1_cntrl = c; req1_in1 = x; req1_in2 = y; req1_lock = lk;
    end else begin
      req0_valid = 1; req0_cntrl = c; req0_in1 = x; req0_in2 = y; req0_lock = lk;
    end
  endtask
  task automatic issue(input bit p, input logic [3:0] c, input logic [31:0] x, input logic [31:0] y, input bit lk);
    bit ok;
    ok = 0;
    drive(p, c, x, y, lk);
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = p ? req1_ready : req0_ready;
      step();
    end
    if (p) req1_valid = 0; else req0_valid = 0;
    chk("issue_accepted", ok, 1);
  endtask
  task automatic do_reset;
    reset = 1;
    step();
    step();
    reset = 0;
  endtask
  logic [3:0]  t_c[5] = '{4'b0000, 4'b0001, 4'b0110, 4'b0110, 4'b0010};
  logic [31:0] t_a[5] = '{32'h0000F0F0, 32'h0, 32'd3, 32'd5, 32'h80000000};
  logic [31:0] t_b[5] = '{32'h0000FF00, 32'h0, 32'd5, 32'd3, 32'h80000000};
  logic [31:0] t_r[5] = '{32'h0000F000, 32'h0, 32'hFFFFFFFE, 32'd2, 32'h0};
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    reset = 1;
    req0_valid = 0; req0_cntrl = 0; req0_in1 = 0; req0_in2 = 0; req0_lock = 0;
    req1_valid = 0; req1_cntrl = 0; req1_in1 = 0; req1_in2 = 0; req1_lock = 0;
    rsp0_ready = 0; rsp1_ready = 0;
    repeat (3) step();
    @(negedge clk);
    chk("rst_rsp0_valid", rsp0_valid, 0);
    chk("rst_result", rsp_result, 0);
    step();
    reset = 0;
    rsp0_ready = 1;
    drive(0, 4'b0010, 32'd5, 32'd7, 0);
    @(negedge clk);
    chk("t1_ready", req0_ready, 1);
    step();
    req0_valid = 0;
    @(negedge clk);
    chk("t1_valid", rsp0_valid, 1);
    chk("t1_result", rsp_result, 32'd12);
    chk("t1_zero", rsp_zero, 0);
    chk("t1_err", rsp_err, 0);
    step();
    do_reset();
    rsp0_ready = 1; rsp1_ready = 1;
    drive(0, 4'b0110, 32'd9, 32'd9, 0);
    drive(1, 4'b0001, 32'hF0, 32'h0F, 0);
    @(negedge clk);
    chk("t2_grant0", req0_ready, 1);
    chk("t2_wait1", req1_ready, 0);
    step();
    req0_valid = 0;
    @(negedge clk);
    chk("t2_grant1", req1_ready, 1);
    chk("t2_rsp0", rsp0_valid, 1);
    chk("t2_res0", rsp_result, 0);
    chk("t2_zero0", rsp_zero, 1);
    step();
    req1_valid = 0;
    @(negedge clk);
    chk("t2_rsp1", rsp1_valid, 1);
    chk("t2_res1", rsp_result, 32'hFF);
    step();
    rsp0_ready = 0;
    issue(0, 4'b0010, 32'd1, 32'd2, 0);
    drive(1, 4'b0010, 32'd10, 32'd20, 0);
    repeat (3) begin
      @(negedge clk);
      chk("t3_stall", req1_ready, 0);
      chk("t3_hold", rsp_result, 32'd3);
      step();
    end
    rsp0_ready = 1;
    @(negedge clk);
    chk("t3_drain_accept", req1_ready, 1);
    step();
    req1_valid = 0;
    @(negedge clk);
    chk("t3_rsp1", rsp1_valid, 1);
    chk("t3_res", rsp_result, 32'd30);
    step();
    issue(1, 4'b1111, 32'd3, 32'd4, 0);
    @(negedge clk);
    chk("t4_valid", rsp1_valid, 1);
    chk("t4_err", rsp_err, 1);
    chk("t4_res", rsp_result, 0);
    chk("t4_zero", rsp_zero, 0);
    step();
    issue(1, 4'b0010, 32'hFFFFFFFF, 32'd1, 0);
    @(negedge clk);
    chk("t4_wrap_res", rsp_result, 0);
    chk("t4_wrap_zero", rsp_zero, 1);
    chk("t4_wrap_err", rsp_err, 0);
    step();
    for (int i = 0; i < 5; i++) begin
      issue(i[0], t_c[i], t_a[i], t_b[i], 0);
      @(negedge clk);
      chk("tbl_res", rsp_result, t_r[i]);
      chk("tbl_zero", rsp_zero, t_r[i] == 0);
      step();
    end
    rsp1_ready = 0;
    issue(1, 4'b0010, 32'd2, 32'd2, 0);
    drive(0, 4'b0110, 32'd8, 32'd3, 0);
    drive(1, 4'b0000, 32'hFFFFFFFF, 32'd7, 0);
    reset = 1;
    @(negedge clk);
    chk("t5_rst_r0", req0_ready, 0);
    chk("t5_rst_r1", req1_ready, 0);
    chk("t5_pre_v1", rsp1_valid, 1);
    step();
    @(negedge clk);
    chk("t5_flushed", rsp1_valid, 0);
    chk("t5_rst_r0b", req0_ready, 0);
    step();
    reset = 0; rsp0_ready = 1; rsp1_ready = 1;
    @(negedge clk);
    chk("t5_first0", req0_ready, !PRIO_INIT);
    chk("t5_first1", req1_ready, PRIO_INIT);
    step();
    if (PRIO_INIT) req1_valid = 0; else req0_valid = 0;
    @(negedge clk);
    chk("t5_second", PRIO_INIT ? req0_ready : req1_ready, 1);
    step();
    req0_valid = 0; req1_valid = 0;
`ifdef ALU_ARB_LOCK_EN
    do_reset();
    drive(1, 4'b0010, 32'd1, 32'd1, 0);
    drive(0, 4'b0010, 32'd0, 32'd0, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t6_lock_g0", req0_ready, 1);
      chk("t6_lock_w1", req1_ready, 0);
      step();
      req0_lock = (i + 1 < 3);
      req0_in1 = i + 1;
    end
    req0_valid = 0;
    @(negedge clk);
    chk("t6_release", req1_ready, 1);
    step();
    drive(0, 4'b0010, 32'd5, 32'd5, 1);
    @(negedge clk);
    chk("t6_acquire", req0_ready, 1);
    step();
    req0_valid = 0;
    @(negedge clk);
    chk("t6_owner_idle", req1_ready, 0);
    step();
    req0_valid = 1;
    repeat (LOCK_MAX - 1) begin
      @(negedge clk);
      chk("t6_held", req0_ready, 1);
      step();
    end
    @(negedge clk);
    chk("t6_force_r1", req1_ready, 1);
    chk("t6_force_r0", req0_ready, 0);
    step();
    req0_valid = 0; req1_valid = 0;
`endif
    repeat (3) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
